// File: rtl/msp_trace_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msp_trace_pkg
// Description : Shared record layout and widths for the instruction tracer.
// Revision    : 1.0 - initial release
// ============================================================================
package msp_trace_pkg;

    localparam int unsigned c_PC_W     = 16;
    localparam int unsigned c_OP_W     = 16;
    localparam int unsigned c_IRQN_W   = 4;
    localparam int unsigned c_SEQ_W    = 32;
    localparam int unsigned c_DROP_W   = 16;
    localparam int unsigned c_CYC_W    = 16;

    // The cycle field sits on top so a non-default CYC_W leaves every other offset fixed.
    localparam int unsigned c_PC_LSB   = 0;
    localparam int unsigned c_OP_LSB   = c_PC_LSB   + c_PC_W;
    localparam int unsigned c_IRQ_LSB  = c_OP_LSB   + c_OP_W;
    localparam int unsigned c_IRQN_LSB = c_IRQ_LSB  + 1;
    localparam int unsigned c_SEQ_LSB  = c_IRQN_LSB + c_IRQN_W;
    localparam int unsigned c_CYC_LSB  = c_SEQ_LSB  + c_SEQ_W;
    localparam int unsigned c_REC_W    = c_CYC_LSB  + c_CYC_W;

    function automatic int unsigned rec_width(input int unsigned cyc_w);
        return c_CYC_LSB + cyc_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msp_trace_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msp_trace_fifo
// Description : Synchronous show-ahead record FIFO with occupancy level.
// Revision    : 1.0 - initial release
// ============================================================================
module msp_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 85
) (
    input  logic                     mclk,
    input  logic                     puc_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_acc
);

    localparam int unsigned c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_full;
    logic             w_pop_acc;

    // Level tops out at exactly DEPTH, which is the only value with the MSB set.
    assign w_full    = r_level[c_AW];
    assign empty     = (r_level == '0);
    assign w_pop_acc = pop & ~empty;
    assign push_acc  = push & (~w_full | w_pop_acc);
    assign rdata     = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge mclk) begin
        if (push_acc) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push_acc, w_pop_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/msp_inst_trace.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : msp_inst_trace
// Description : Captures one record per executed instruction / IRQ entry.
// Revision    : 1.0 - initial release
// ============================================================================
module msp_inst_trace
    import msp_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CYC_W = 16
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    decode,
    input  logic [15:0]             ir,
    input  logic [15:0]             pc,
    input  logic                    irq_detect,
    input  logic [3:0]              irq_num,
    input  logic                    trace_en,
    input  logic                    trc_ready,
    input  logic                    clr_ovf,
    output logic                    trc_valid,
    output logic [15:0]             trc_pc,
    output logic [15:0]             trc_opcode,
    output logic                    trc_irq,
    output logic [3:0]              trc_irq_num,
    output logic [CYC_W-1:0]        trc_cycles,
    output logic [31:0]             trc_seq,
    output logic [$clog2(DEPTH):0]  trc_level,
    output logic                    trc_overflow,
    output logic [15:0]             trc_drops
);

    localparam int unsigned c_REC_W = rec_width(CYC_W);

    logic [c_PC_W-1:0]   r_cur_pc;
    logic [c_OP_W-1:0]   r_cur_ir;
    logic                r_cur_irq;
    logic [c_IRQN_W-1:0] r_cur_irqn;
    logic                r_cur_valid;
    logic [CYC_W-1:0]    r_cyc_cnt;
    logic [c_SEQ_W-1:0]  r_seq;
    logic                r_overflow;
    logic [c_DROP_W-1:0] r_drops;

    logic                w_attempt;
    logic                w_push;
    logic                w_push_acc;
    logic                w_drop;
    logic                w_empty;
    logic [c_REC_W-1:0]  w_rec;
    logic [c_REC_W-1:0]  w_head;

    // A decode closes the instruction latched by the previous decode.
    assign w_attempt = decode & r_cur_valid;
    assign w_push    = w_attempt & trace_en;
    assign w_drop    = w_push & ~w_push_acc;
    assign w_rec     = {r_cyc_cnt, r_seq, r_cur_irqn, r_cur_irq, r_cur_ir, r_cur_pc};

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_cur_pc    <= '0;
            r_cur_ir    <= '0;
            r_cur_irq   <= 1'b0;
            r_cur_irqn  <= '0;
            r_cur_valid <= 1'b0;
            r_cyc_cnt   <= '0;
            r_seq       <= '0;
        end else begin
            if (decode) begin
                r_cur_pc    <= pc;
                r_cur_ir    <= ir;
                r_cur_irq   <= irq_detect;
                r_cur_irqn  <= irq_num;
                r_cur_valid <= 1'b1;
                r_cyc_cnt   <= CYC_W'(1);
            end else if (r_cyc_cnt != '1) begin
                r_cyc_cnt   <= r_cyc_cnt + 1'b1;
            end
            if (w_attempt) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    // A drop in the same cycle as clr_ovf restarts the count at one.
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf) begin
                r_drops <= c_DROP_W'(1);
            end else if (r_drops != '1) begin
                r_drops <= r_drops + 1'b1;
            end
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end
    end

    msp_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_REC_W)
    ) u_fifo (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .push     (w_push),
        .pop      (trc_ready),
        .wdata    (w_rec),
        .rdata    (w_head),
        .empty    (w_empty),
        .level    (trc_level),
        .push_acc (w_push_acc)
    );

    // Storage is never cleared, so head fields are forced to zero while empty.
    assign trc_valid    = ~w_empty;
    assign trc_pc       = trc_valid ? w_head[c_PC_LSB   +: c_PC_W]   : '0;
    assign trc_opcode   = trc_valid ? w_head[c_OP_LSB   +: c_OP_W]   : '0;
    assign trc_irq      = trc_valid ? w_head[c_IRQ_LSB]              : 1'b0;
    assign trc_irq_num  = trc_valid ? w_head[c_IRQN_LSB +: c_IRQN_W] : '0;
    assign trc_seq      = trc_valid ? w_head[c_SEQ_LSB  +: c_SEQ_W]  : '0;
    assign trc_cycles   = trc_valid ? w_head[c_CYC_LSB  +: CYC_W]    : '0;
    assign trc_overflow = r_overflow;
    assign trc_drops    = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_msp_inst_trace.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_msp_inst_trace
// Description : Directed self-checking bench for msp_inst_trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msp_inst_trace;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        decode = 1'b0;
    logic [15:0] ir = '0;
    logic [15:0] pc = '0;
    logic        irq_detect = 1'b0;
    logic [3:0]  irq_num = '0;
    logic        trace_en = 1'b1;
    logic        trc_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        trc_valid;
    logic [15:0] trc_pc;
    logic [15:0] trc_opcode;
    logic        trc_irq;
    logic [3:0]  trc_irq_num;
    logic [15:0] trc_cycles;
    logic [31:0] trc_seq;
    logic [4:0]  trc_level;
    logic        trc_overflow;
    logic [15:0] trc_drops;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 mclk = ~mclk;

    msp_inst_trace #(.DEPTH(16), .CYC_W(16)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .decode(decode), .ir(ir), .pc(pc),
        .irq_detect(irq_detect), .irq_num(irq_num), .trace_en(trace_en),
        .trc_ready(trc_ready), .clr_ovf(clr_ovf), .trc_valid(trc_valid),
        .trc_pc(trc_pc), .trc_opcode(trc_opcode), .trc_irq(trc_irq),
        .trc_irq_num(trc_irq_num), .trc_cycles(trc_cycles), .trc_seq(trc_seq),
        .trc_level(trc_level), .trc_overflow(trc_overflow), .trc_drops(trc_drops)
    );

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic dec(input logic [15:0] p, input logic [15:0] i);
        decode = 1'b1; pc = p; ir = i;
        tick();
        decode = 1'b0;
    endtask

    task automatic do_reset();
        puc_rst = 1'b1; decode = 1'b0; trc_ready = 1'b0; clr_ovf = 1'b0;
        trace_en = 1'b1; irq_detect = 1'b0; irq_num = '0;
        repeat (2) tick();
        puc_rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if (trc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b exp 0", trc_valid); end
        n_cmp++; if (trc_level !== 5'd0) begin n_bad++; $display("FAIL rst_level got %0d exp 0", trc_level); end
        n_cmp++; if (trc_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0b exp 0", trc_overflow); end
        n_cmp++; if (trc_drops !== 16'd0) begin n_bad++; $display("FAIL rst_drops got %0d exp 0", trc_drops); end
        n_cmp++; if (trc_pc !== 16'h0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", trc_pc); end
        n_cmp++; if (trc_seq !== 32'h0) begin n_bad++; $display("FAIL rst_seq got %h exp 0", trc_seq); end
        n_cmp++; if (trc_cycles !== 16'h0) begin n_bad++; $display("FAIL rst_cycles got %h exp 0", trc_cycles); end
        n_cmp++; if ({trc_irq, trc_irq_num, trc_opcode} !== 21'h0) begin n_bad++; $display("FAIL rst_head got %h exp 0", {trc_irq, trc_irq_num, trc_opcode}); end
        puc_rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        dec(16'hF000, 16'h4031);
        n_cmp++; if (trc_valid !== 1'b0) begin n_bad++; $display("FAIL basic_first_nopush got %0b exp 0", trc_valid); end
        tick(); tick();
        dec(16'hF002, 16'h5031);
        n_cmp++; if (trc_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b exp 1", trc_valid); end
        n_cmp++; if (trc_pc !== 16'hF000) begin n_bad++; $display("FAIL basic_pc0 got %h exp F000", trc_pc); end
        n_cmp++; if (trc_opcode !== 16'h4031) begin n_bad++; $display("FAIL basic_op0 got %h exp 4031", trc_opcode); end
        n_cmp++; if (trc_cycles !== 16'd3) begin n_bad++; $display("FAIL basic_cyc0 got %0d exp 3", trc_cycles); end
        n_cmp++; if (trc_seq !== 32'd0) begin n_bad++; $display("FAIL basic_seq0 got %0d exp 0", trc_seq); end
        n_cmp++; if (trc_irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq0 got %0b exp 0", trc_irq); end
        tick();
        dec(16'hF004, 16'h6031);
        n_cmp++; if (trc_level !== 5'd2) begin n_bad++; $display("FAIL basic_level2 got %0d exp 2", trc_level); end
        n_cmp++; if (trc_pc !== 16'hF000) begin n_bad++; $display("FAIL basic_head_hold got %h exp F000", trc_pc); end
        trc_ready = 1'b1; tick(); trc_ready = 1'b0;
        n_cmp++; if (trc_pc !== 16'hF002) begin n_bad++; $display("FAIL basic_pc1 got %h exp F002", trc_pc); end
        n_cmp++; if (trc_opcode !== 16'h5031) begin n_bad++; $display("FAIL basic_op1 got %h exp 5031", trc_opcode); end
        n_cmp++; if (trc_cycles !== 16'd2) begin n_bad++; $display("FAIL basic_cyc1 got %0d exp 2", trc_cycles); end
        n_cmp++; if (trc_seq !== 32'd1) begin n_bad++; $display("FAIL basic_seq1 got %0d exp 1", trc_seq); end
        n_cmp++; if (trc_level !== 5'd1) begin n_bad++; $display("FAIL basic_level1 got %0d exp 1", trc_level); end
        trc_ready = 1'b1; tick();
        n_cmp++; if (trc_valid !== 1'b0) begin n_bad++; $display("FAIL basic_empty_valid got %0b exp 0", trc_valid); end
        n_cmp++; if (trc_pc !== 16'h0) begin n_bad++; $display("FAIL basic_empty_pc got %h exp 0", trc_pc); end
        tick(); trc_ready = 1'b0;
        n_cmp++; if (trc_level !== 5'd0) begin n_bad++; $display("FAIL basic_underflow got %0d exp 0", trc_level); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 17; j++) dec(16'hC000 + 16'(2 * j), 16'h1000);
        n_cmp++; if (trc_level !== 5'd16) begin n_bad++; $display("FAIL b2b_full got %0d exp 16", trc_level); end
        trc_ready = 1'b1;
        dec(16'hC022, 16'h1000);
        trc_ready = 1'b0;
        n_cmp++; if (trc_level !== 5'd16) begin n_bad++; $display("FAIL b2b_level got %0d exp 16", trc_level); end
        n_cmp++; if (trc_drops !== 16'd0) begin n_bad++; $display("FAIL b2b_drops got %0d exp 0", trc_drops); end
        n_cmp++; if (trc_overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got %0b exp 0", trc_overflow); end
        n_cmp++; if (trc_seq !== 32'd1) begin n_bad++; $display("FAIL b2b_head got %0d exp 1", trc_seq); end
        trc_ready = 1'b1; repeat (15) tick(); trc_ready = 1'b0;
        n_cmp++; if (trc_seq !== 32'd16) begin n_bad++; $display("FAIL b2b_tail_seq got %0d exp 16", trc_seq); end
        n_cmp++; if (trc_pc !== 16'hC020) begin n_bad++; $display("FAIL b2b_tail_pc got %h exp C020", trc_pc); end
        n_cmp++; if (trc_level !== 5'd1) begin n_bad++; $display("FAIL b2b_last_level got %0d exp 1", trc_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int j = 0; j < 21; j++) dec(16'hD000 + 16'(2 * j), 16'h2000);
        n_cmp++; if (trc_level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d exp 16", trc_level); end
        n_cmp++; if (trc_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0b exp 1", trc_overflow); end
        n_cmp++; if (trc_drops !== 16'd4) begin n_bad++; $display("FAIL ovf_drops got %0d exp 4", trc_drops); end
        n_cmp++; if (trc_seq !== 32'd0) begin n_bad++; $display("FAIL ovf_head_seq got %0d exp 0", trc_seq); end
        n_cmp++; if (trc_pc !== 16'hD000) begin n_bad++; $display("FAIL ovf_head_pc got %h exp D000", trc_pc); end
        n_cmp++; if (trc_cycles !== 16'd1) begin n_bad++; $display("FAIL ovf_head_cyc got %0d exp 1", trc_cycles); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_cmp++; if (trc_overflow !== 1'b0) begin n_bad++; $display("FAIL clr_flag got %0b exp 0", trc_overflow); end
        n_cmp++; if (trc_drops !== 16'd0) begin n_bad++; $display("FAIL clr_drops got %0d exp 0", trc_drops); end
        clr_ovf = 1'b1;
        dec(16'hD02A, 16'h2000);
        clr_ovf = 1'b0;
        n_cmp++; if (trc_overflow !== 1'b1) begin n_bad++; $display("FAIL clr_drop_flag got %0b exp 1", trc_overflow); end
        n_cmp++; if (trc_drops !== 16'd1) begin n_bad++; $display("FAIL clr_drop_cnt got %0d exp 1", trc_drops); end
        trc_ready = 1'b1; repeat (15) tick(); trc_ready = 1'b0;
        n_cmp++; if (trc_seq !== 32'd15) begin n_bad++; $display("FAIL ovf_last_seq got %0d exp 15", trc_seq); end
        n_cmp++; if (trc_pc !== 16'hD01E) begin n_bad++; $display("FAIL ovf_last_pc got %h exp D01E", trc_pc); end
    endtask

    task automatic test_irq();
        do_reset();
        irq_detect = 1'b1; irq_num = 4'hE;
        dec(16'h8000, 16'h1300);
        irq_detect = 1'b0; irq_num = 4'h0;
        dec(16'h8010, 16'h4303);
        n_cmp++; if (trc_irq !== 1'b1) begin n_bad++; $display("FAIL irq_flag got %0b exp 1", trc_irq); end
        n_cmp++; if (trc_irq_num !== 4'hE) begin n_bad++; $display("FAIL irq_num got %h exp E", trc_irq_num); end
        n_cmp++; if (trc_pc !== 16'h8000) begin n_bad++; $display("FAIL irq_pc got %h exp 8000", trc_pc); end
        dec(16'h8020, 16'h4303);
        trc_ready = 1'b1; tick(); trc_ready = 1'b0;
        n_cmp++; if ({trc_irq, trc_irq_num} !== 5'h0) begin n_bad++; $display("FAIL irq_next got %h exp 0", {trc_irq, trc_irq_num}); end
        n_cmp++; if (trc_pc !== 16'h8010) begin n_bad++; $display("FAIL irq_next_pc got %h exp 8010", trc_pc); end
    endtask

    task automatic test_trace_en();
        do_reset();
        dec(16'hA000, 16'h3000);
        trace_en = 1'b0;
        dec(16'hA002, 16'h3000);
        dec(16'hA004, 16'h3000);
        dec(16'hA006, 16'h3000);
        n_cmp++; if (trc_level !== 5'd0) begin n_bad++; $display("FAIL ten_suppressed got %0d exp 0", trc_level); end
        trace_en = 1'b1;
        dec(16'hA008, 16'h3000);
        n_cmp++; if (trc_level !== 5'd1) begin n_bad++; $display("FAIL ten_level got %0d exp 1", trc_level); end
        n_cmp++; if (trc_seq !== 32'd3) begin n_bad++; $display("FAIL ten_seq got %0d exp 3", trc_seq); end
        n_cmp++; if (trc_pc !== 16'hA006) begin n_bad++; $display("FAIL ten_pc got %h exp A006", trc_pc); end
        n_cmp++; if (trc_drops !== 16'd0) begin n_bad++; $display("FAIL ten_drops got %0d exp 0", trc_drops); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        dec(16'hB000, 16'h4000);
        repeat (70000) tick();
        dec(16'hB002, 16'h4000);
        n_cmp++; if (trc_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cycles got %h exp FFFF", trc_cycles); end
        n_cmp++; if (trc_seq !== 32'd0) begin n_bad++; $display("FAIL sat_seq got %0d exp 0", trc_seq); end
        for (int j = 0; j < 4; j++) dec(16'hB004 + 16'(2 * j), 16'h4000);
        n_cmp++; if (trc_level !== 5'd5) begin n_bad++; $display("FAIL mid_level got %0d exp 5", trc_level); end
        #2 puc_rst = 1'b1;
        #1;
        n_cmp++; if (trc_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid got %0b exp 0", trc_valid); end
        n_cmp++; if (trc_level !== 5'd0) begin n_bad++; $display("FAIL async_level got %0d exp 0", trc_level); end
        n_cmp++; if (trc_pc !== 16'h0) begin n_bad++; $display("FAIL async_pc got %h exp 0", trc_pc); end
        tick();
        puc_rst = 1'b0;
        dec(16'hE000, 16'h4000);
        dec(16'hE002, 16'h4000);
        n_cmp++; if (trc_seq !== 32'd0) begin n_bad++; $display("FAIL post_rst_seq got %0d exp 0", trc_seq); end
        n_cmp++; if (trc_level !== 5'd1) begin n_bad++; $display("FAIL post_rst_level got %0d exp 1", trc_level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_trace_en();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
